smart_lighting_ctrl: RTL and testbench
======================================

// Module: smart_lighting_ctrl
// PURPOSE
//  Multi-channel smart-lighting controller. One independent lamp FSM per channel.
//  Auto mode: lamp driven by presence and ambient darkness, with a post-presence hold timer.
//  Manual mode: lamp toggled by push-button. Sits between synchronised sensor/button inputs and lamp drivers.
// PARAMETERS
//  NUM_CH          4       number of lamp channels (>=1)
//  HOLD_CYCLES     1000    cycles lamp stays lit after presence drops (0 = turn off immediately)
//  MANUAL_TIMEOUT  100000  idle cycles before manual mode reverts to auto (used only with SLC_MANUAL_TIMEOUT_EN; >=1)
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst_n       in   1       asynchronous active-low reset
//  mode_btn    in   NUM_CH  per-channel auto/manual toggle button (level, pre-synchronised)
//  tog_btn     in   NUM_CH  per-channel manual on/off button (level, pre-synchronised)
//  presence    in   NUM_CH  per-channel occupancy sensor, 1 = occupied
//  dark        in   1       global ambient sensor, 1 = dark
//  lamp        out  NUM_CH  lamp drive, 1 = on
//  manual_led  out  NUM_CH  mode indicator, 1 = channel in manual mode
//  any_on      out  1       OR of lamp
// BEHAVIOUR
//  - Reset: all channels AUTO_OFF; lamp=0, manual_led=0, any_on=0; counters=0; button-history regs=0.
//  - Button edges: mode_e = mode_btn & ~mode_btn_q; same for tog_e. A held button acts once.
//  - A rising edge present before posedge k changes state at posedge k.
//  - Outputs are decoded from the state register only: 1-cycle latency, glitch-free.
//  - States:
//    - AUTO_OFF   lamp=0  led=0
//    - AUTO_ON    lamp=1  led=0
//    - AUTO_HOLD  lamp=1  led=0
//    - MAN_OFF    lamp=0  led=1
//    - MAN_ON     lamp=1  led=1
//  - Transitions (priority top-down in each state):
//    - AUTO_OFF:  mode_e -> MAN_OFF; presence&dark -> AUTO_ON.
//    - AUTO_ON:   mode_e -> MAN_ON; !dark -> AUTO_OFF; !presence -> AUTO_HOLD with cnt=HOLD_CYCLES-1
//      (AUTO_OFF if HOLD_CYCLES==0).
//    - AUTO_HOLD: mode_e -> MAN_ON; !dark -> AUTO_OFF; presence -> AUTO_ON; cnt==0 -> AUTO_OFF; else cnt--.
//      Lamp stays lit exactly HOLD_CYCLES cycles after the posedge that sampled presence low.
//    - MAN_OFF:   mode_e -> AUTO_OFF; tog_e -> MAN_ON.
//    - MAN_ON:    mode_e -> AUTO_HOLD with cnt=HOLD_CYCLES-1 (AUTO_OFF if HOLD_CYCLES==0); tog_e -> MAN_OFF.
//  - Simultaneous mode_e and tog_e: mode_e wins; tog_e is discarded, not deferred.
//  - tog_e in auto states is ignored. presence/dark are ignored in manual states.
//  - Counter width CNT_W = $clog2(max(HOLD_CYCLES, MANUAL_TIMEOUT)+1); it never wraps and saturates at 0.
//  - Channels are fully independent; the same-cycle events on different channels do not interact.
//  - Reset asserted mid-hold or mid-manual: immediate return to the reset state; no residual count.
//  - Illegal state encoding -> AUTO_OFF on next clock.
// CONFIGURATION
//  SLC_MANUAL_TIMEOUT_EN defined:
//   - On entry to MAN_OFF/MAN_ON, and on every tog_e, cnt=MANUAL_TIMEOUT-1.
//   - cnt decrements each idle cycle.
//   - On cnt==0 with no edge: MAN_OFF -> AUTO_OFF; MAN_ON -> AUTO_HOLD (cnt reload as above).
//   - mode_e or tog_e in the expiry cycle takes priority over expiry.
//  SLC_MANUAL_TIMEOUT_EN undefined: manual mode persists until mode_e. MANUAL_TIMEOUT is unused and
//   excluded from CNT_W.
// STRUCTURE
//  - slc_pkg: slc_state_t enum (logic [2:0]); encoding constants; max() helper function for CNT_W.
//  - slc_channel: one-channel FSM, counter and edge registers. Instantiated NUM_CH times in a
//   generate loop; top adds only the any_on reduction.
// TESTING (NUM_CH=2, HOLD_CYCLES=3, MANUAL_TIMEOUT=5)
//  - Reset: rst_n=0 with arbitrary inputs -> lamp=00, manual_led=00, any_on=0. Outputs are held while low.
//  - Auto hold, ch0:
//    - dark=1, presence[0]=1 -> lamp[0]=1 after 1 clk.
//    - Drop presence -> lamp[0] stays 1 for 3 clks, then 0.
//    - Re-raise presence during hold -> lamp stays 1.
//  - Daylight: in AUTO_ON/AUTO_HOLD, dark->0 -> lamp=0 next clk, no hold.
//  - Manual, ch1:
//    - mode_btn[1] pulse -> manual_led[1]=1.
//    - tog_btn[1] held 10 clks -> lamp[1] toggles once.
//    - mode_btn+tog_btn rise same clk -> only mode change.
//    - ch0 unaffected throughout.
//  - MAN_ON + mode_e -> AUTO_HOLD: lamp=1 for 3 clks, then 0 if presence=0.
//  - Timeout (SLC_MANUAL_TIMEOUT_EN):
//    - MAN_ON idle 5 clks -> manual_led=0, lamp holds 3 clks, then 0.
//    - tog_e at clk 4 restarts the 5-cycle window.
//    - Without the macro, idle 50 clks -> still manual.

Source files
------------

// File: rtl/slc_pkg.sv
// rtl/slc_pkg.sv - shared state encoding and helpers for the smart lighting controller
package slc_pkg;

   localparam int SLC_STATE_W = 3;

   typedef enum logic [SLC_STATE_W-1:0] {
      AUTO_OFF  = 3'd0,
      AUTO_ON   = 3'd1,
      AUTO_HOLD = 3'd2,
      MAN_OFF   = 3'd3,
      MAN_ON    = 3'd4
   } slc_state_t;

   function automatic int max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic lamp_of(input slc_state_t s);
      return (s == AUTO_ON) || (s == AUTO_HOLD) || (s == MAN_ON);
   endfunction

   function automatic logic led_of(input slc_state_t s);
      return (s == MAN_OFF) || (s == MAN_ON);
   endfunction

endpackage

// File: rtl/slc_channel.sv
// rtl/slc_channel.sv - one lamp channel: button edge detect, mode FSM, hold/idle counter
// Optional manual-mode idle timeout enabled by SLC_MANUAL_TIMEOUT_EN.
module slc_channel
   import slc_pkg::*;
#(
   parameter int HOLD_CYCLES    = 1000,
   parameter int MANUAL_TIMEOUT = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mode_btn,
   input  logic tog_btn,
   input  logic presence,
   input  logic dark,
   output logic lamp,
   output logic manual_led
);

`ifdef SLC_MANUAL_TIMEOUT_EN
   localparam int CNT_MAX = max(HOLD_CYCLES, MANUAL_TIMEOUT);
`else
   localparam int CNT_MAX = HOLD_CYCLES;
`endif
   localparam int CNT_W = max($clog2(CNT_MAX + 1), 1);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
`ifdef SLC_MANUAL_TIMEOUT_EN
   localparam logic [CNT_W-1:0] MAN_LOAD  = CNT_W'((MANUAL_TIMEOUT > 0) ? MANUAL_TIMEOUT - 1 : 0);
`else
   localparam logic [CNT_W-1:0] MAN_LOAD  = '0;
`endif

   if (MANUAL_TIMEOUT < 1 || HOLD_CYCLES < 0) begin : g_bad_param
      $error("slc_channel: HOLD_CYCLES must be >= 0 and MANUAL_TIMEOUT >= 1");
   end

   slc_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             mode_q, tog_q;
   logic             mode_e, tog_e;

   assign mode_e = mode_btn & ~mode_q;
   assign tog_e  = tog_btn  & ~tog_q;

   // Leaving a lit state without presence goes through the hold window unless it is empty.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         AUTO_OFF: begin
            if (mode_e) begin
               state_nxt = MAN_OFF;
               cnt_nxt   = MAN_LOAD;
            end else if (presence && dark) begin
               state_nxt = AUTO_ON;
            end
         end
         AUTO_ON: begin
            if (mode_e) begin
               state_nxt = MAN_ON;
               cnt_nxt   = MAN_LOAD;
            end else if (!dark) begin
               state_nxt = AUTO_OFF;
            end else if (!presence) begin
               state_nxt = (HOLD_CYCLES == 0) ? AUTO_OFF : AUTO_HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end
         AUTO_HOLD: begin
            if (mode_e) begin
               state_nxt = MAN_ON;
               cnt_nxt   = MAN_LOAD;
            end else if (!dark) begin
               state_nxt = AUTO_OFF;
            end else if (presence) begin
               state_nxt = AUTO_ON;
            end else if (cnt == '0) begin
               state_nxt = AUTO_OFF;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         MAN_OFF: begin
            if (mode_e) begin
               state_nxt = AUTO_OFF;
            end else if (tog_e) begin
               state_nxt = MAN_ON;
               cnt_nxt   = MAN_LOAD;
            end
`ifdef SLC_MANUAL_TIMEOUT_EN
            else if (cnt == '0) begin
               state_nxt = AUTO_OFF;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
`endif
         end
         MAN_ON: begin
            if (mode_e) begin
               state_nxt = (HOLD_CYCLES == 0) ? AUTO_OFF : AUTO_HOLD;
               cnt_nxt   = HOLD_LOAD;
            end else if (tog_e) begin
               state_nxt = MAN_OFF;
               cnt_nxt   = MAN_LOAD;
            end
`ifdef SLC_MANUAL_TIMEOUT_EN
            else if (cnt == '0) begin
               state_nxt = (HOLD_CYCLES == 0) ? AUTO_OFF : AUTO_HOLD;
               cnt_nxt   = HOLD_LOAD;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
`endif
         end
         default: begin
            state_nxt = AUTO_OFF;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= AUTO_OFF;
         cnt        <= '0;
         mode_q     <= 1'b0;
         tog_q      <= 1'b0;
         lamp       <= 1'b0;
         manual_led <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         mode_q     <= mode_btn;
         tog_q      <= tog_btn;
         lamp       <= lamp_of(state_nxt);
         manual_led <= led_of(state_nxt);
      end
   end

endmodule

// File: rtl/smart_lighting_ctrl.sv
// rtl/smart_lighting_ctrl.sv - multi-channel smart lighting controller top
// Optional manual-mode idle timeout enabled by SLC_MANUAL_TIMEOUT_EN.
module smart_lighting_ctrl
   import slc_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int HOLD_CYCLES    = 1000,
   parameter int MANUAL_TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] mode_btn,
   input  logic [NUM_CH-1:0] tog_btn,
   input  logic [NUM_CH-1:0] presence,
   input  logic              dark,
   output logic [NUM_CH-1:0] lamp,
   output logic [NUM_CH-1:0] manual_led,
   output logic              any_on
);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      slc_channel #(
         .HOLD_CYCLES    (HOLD_CYCLES),
         .MANUAL_TIMEOUT (MANUAL_TIMEOUT)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .mode_btn   (mode_btn[gi]),
         .tog_btn    (tog_btn[gi]),
         .presence   (presence[gi]),
         .dark       (dark),
         .lamp       (lamp[gi]),
         .manual_led (manual_led[gi])
      );
   end

   assign any_on = |lamp;

endmodule

// File: tb/tb_smart_lighting_ctrl.sv
// tb/tb_smart_lighting_ctrl.sv - self-checking bench for smart_lighting_ctrl (aware of SLC_MANUAL_TIMEOUT_EN)
module tb_smart_lighting_ctrl;

   localparam int NUM_CH = 2;
   localparam int HOLD   = 3;
   localparam int MT     = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NUM_CH-1:0] mode_btn, tog_btn, presence;
   logic              dark;
   logic [NUM_CH-1:0] lamp, manual_led;
   logic              any_on;

   int checks   = 0;
   int failures = 0;

   // Reference model: per channel a mode flag, a light flag, remaining hold budget and idle count.
   logic [NUM_CH-1:0] m_lit, m_man, m_mq, m_tq;
   int                m_rem  [NUM_CH];
   int                m_idle [NUM_CH];

   smart_lighting_ctrl #(
      .NUM_CH         (NUM_CH),
      .HOLD_CYCLES    (HOLD),
      .MANUAL_TIMEOUT (MT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_btn   (mode_btn),
      .tog_btn    (tog_btn),
      .presence   (presence),
      .dark       (dark),
      .lamp       (lamp),
      .manual_led (manual_led),
      .any_on     (any_on)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lit = '0; m_man = '0; m_mq = '0; m_tq = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_rem[c]  = 0;
         m_idle[c] = 0;
      end
   endtask

   task automatic leave_manual(input int c);
      m_man[c] = 1'b0;
      if (m_lit[c]) begin
         if (HOLD == 0) m_lit[c] = 1'b0;
         else           m_rem[c] = HOLD - 1;
      end
   endtask

   task automatic model_step();
      logic me, te;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         me = mode_btn[c] & ~m_mq[c];
         te = tog_btn[c]  & ~m_tq[c];
         m_mq[c] = mode_btn[c];
         m_tq[c] = tog_btn[c];
         if (!m_man[c]) begin
            if (me) begin
               m_man[c]  = 1'b1;
               m_idle[c] = 0;
            end else if (!m_lit[c]) begin
               if (presence[c] && dark) begin
                  m_lit[c] = 1'b1;
                  m_rem[c] = HOLD;
               end
            end else if (!dark) begin
               m_lit[c] = 1'b0;
            end else if (presence[c]) begin
               m_rem[c] = HOLD;
            end else if (m_rem[c] == 0) begin
               m_lit[c] = 1'b0;
            end else begin
               m_rem[c]--;
            end
         end else begin
            if (me) begin
               leave_manual(c);
            end else if (te) begin
               m_lit[c]  = ~m_lit[c];
               m_idle[c] = 0;
            end else begin
`ifdef SLC_MANUAL_TIMEOUT_EN
               m_idle[c]++;
               if (m_idle[c] == MT) leave_manual(c);
`endif
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_lamp"}, lamp, m_lit);
      chk({tag, "_led"}, manual_led, m_man);
      chk({tag, "_any"}, {1'b0, any_on}, {1'b0, |m_lit});
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         #1;
         check_all("step");
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst_async");
      mode_btn = 2'($urandom); tog_btn = 2'($urandom);
      presence = 2'($urandom); dark = 1'($urandom);
      step(2);
      chk("rst_held_lamp", lamp, 2'b00);
      rst_n = 1'b1;
      mode_btn = '0; tog_btn = '0; presence = '0; dark = 1'b1;
   endtask

   initial begin
      model_reset();
      rst_n = 1'b0;
      mode_btn = 2'b11; tog_btn = 2'b10; presence = 2'b11; dark = 1'b1;
      step(3);
      chk("reset_lamp", lamp, 2'b00);
      chk("reset_led", manual_led, 2'b00);
      chk("reset_any", {1'b0, any_on}, 2'b00);
      rst_n = 1'b1;
      mode_btn = '0; tog_btn = '0; presence = '0; dark = 1'b0;
      step(2);

      // auto hold on channel 0
      dark = 1'b1; presence[0] = 1'b1;
      step(1);
      chk("auto_on", {1'b0, lamp[0]}, 2'b01);
      step(2);
      presence[0] = 1'b0;
      for (int i = 0; i < HOLD; i++) begin
         step(1);
         chk("hold_lit", {1'b0, lamp[0]}, 2'b01);
      end
      step(1);
      chk("hold_expired", {1'b0, lamp[0]}, 2'b00);
      presence[0] = 1'b1; step(1);
      presence[0] = 1'b0; step(2);
      presence[0] = 1'b1; step(1);
      chk("hold_reraise", {1'b0, lamp[0]}, 2'b01);
      step(3);

      // daylight cancels on and hold without a hold window
      dark = 1'b0; step(1);
      chk("day_from_on", {1'b0, lamp[0]}, 2'b00);
      dark = 1'b1; step(1);
      presence[0] = 1'b0; step(1);
      dark = 1'b0; step(1);
      chk("day_from_hold", {1'b0, lamp[0]}, 2'b00);

      // manual on channel 1 while channel 0 runs in auto
      do_reset();
      presence[0] = 1'b1;
      mode_btn[1] = 1'b1; step(1);
      chk("man_led", manual_led, 2'b10);
      mode_btn[1] = 1'b0; step(1);
      tog_btn[1] = 1'b1; step(1);
      chk("man_tog_on", {1'b0, lamp[1]}, 2'b01);
      step(9);
      tog_btn[1] = 1'b0; step(1);
      mode_btn[1] = 1'b1; tog_btn[1] = 1'b1; step(1);
      mode_btn[1] = 1'b0; tog_btn[1] = 1'b0; step(2);

      // MAN_ON released to auto goes through the hold window
      do_reset();
      mode_btn[1] = 1'b1; step(1); mode_btn[1] = 1'b0;
      tog_btn[1]  = 1'b1; step(1); tog_btn[1]  = 1'b0;
      mode_btn[1] = 1'b1; step(1); mode_btn[1] = 1'b0;
      chk("man_to_hold", {manual_led[1], lamp[1]}, 2'b01);
      step(2);
      chk("man_hold_end", {1'b0, lamp[1]}, 2'b01);
      step(1);
      chk("man_hold_off", {1'b0, lamp[1]}, 2'b00);

      // idle manual behaviour
      do_reset();
      mode_btn[1] = 1'b1; step(1); mode_btn[1] = 1'b0;
      tog_btn[1]  = 1'b1; step(1); tog_btn[1]  = 1'b0;
`ifdef SLC_MANUAL_TIMEOUT_EN
      step(MT - 1);
      chk("to_before", {1'b0, manual_led[1]}, 2'b01);
      step(1);
      chk("to_expired", {manual_led[1], lamp[1]}, 2'b01);
      step(HOLD);
      chk("to_hold_off", {1'b0, lamp[1]}, 2'b00);
      mode_btn[1] = 1'b1; step(1); mode_btn[1] = 1'b0;
      tog_btn[1]  = 1'b1; step(1); tog_btn[1]  = 1'b0;
      step(3);
      tog_btn[1] = 1'b1; step(1); tog_btn[1] = 1'b0;
      step(MT - 1);
      chk("to_restart", {1'b0, manual_led[1]}, 2'b01);
      step(1);
      chk("to_restart_exp", {1'b0, manual_led[1]}, 2'b00);
`else
      step(50);
      chk("no_timeout", {manual_led[1], lamp[1]}, 2'b11);
`endif

      // reset mid-hold leaves no residual hold
      do_reset();
      presence[0] = 1'b1; step(2);
      presence[0] = 1'b0; step(1);
      do_reset();
      step(1);
      chk("rst_midhold", lamp, 2'b00);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         dark = ($urandom_range(0, 9) != 0);
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 3) == 0) presence[c] = ~presence[c];
            mode_btn[c] = ($urandom_range(0, 11) == 0);
            tog_btn[c]  = ($urandom_range(0, 4) == 0);
         end
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
